up_axi_master: RTL and testbench



---
 rtl/up_axi_master.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_up_axi_master.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/up_axi_master.sv
// up_axi_master: bridges the single-cycle up register bus to an AXI4-Lite master.
// One transaction is in flight at a time. A read that arrives together with a
// write waits in a 1-deep pending slot. Hung slaves are aborted by a timeout.
//
// Ports:
//   up_clk, up_rstn        clock, async active-low reset
//   up_wreq/waddr/wdata    write request pulse, word address, data
//   up_wack                write done pulse
//   up_rreq/raddr          read request pulse, word address
//   up_rack/rdata          read done pulse, data (zero outside up_rack)
//   up_err                 pulses with an ack on SLVERR/DECERR or timeout
//   up_busy                high while a transaction or pending read is open
//   m_axi_*                AXI4-Lite master channels AW, W, B, AR, R
module up_axi_master #(
    parameter logic [31:0] AXI_ADDRESS_BASE = 32'h00000000,
    parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
    input  logic        up_clk,
    input  logic        up_rstn,
    input  logic        up_wreq,
    input  logic [13:0] up_waddr,
    input  logic [31:0] up_wdata,
    output logic        up_wack,
    input  logic        up_rreq,
    input  logic [13:0] up_raddr,
    output logic [31:0] up_rdata,
    output logic        up_rack,
    output logic        up_err,
    output logic        up_busy,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    input  logic [1:0]  m_axi_bresp,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp
);

    localparam int unsigned UP_AW  = 14;
    localparam int unsigned AXI_AW = 32;
    localparam int unsigned DW     = 32;
    localparam int unsigned CW     = 16;

    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0] DEAD_DATA = 32'hdeaddead;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              pend_abort_q, pend_abort_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic [AXI_AW-1:0] awaddr_q, awaddr_d;
    logic [AXI_AW-1:0] araddr_q, araddr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic              wack_q, wack_d;
    logic              rack_q, rack_d;
    logic              err_q, err_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              busy_q, busy_d;

    logic timeout;
    logic aw_left;
    logic w_left;
    logic write_done;
    logic write_abort;
    logic read_abort;

    // Word address to byte address in the AXI window (32-bit wrap).
    function automatic logic [AXI_AW-1:0] up_to_axi(input logic [UP_AW-1:0] a);
        return AXI_ADDRESS_BASE + AXI_AW'({a, 2'b00});
    endfunction

    // State register and all registered outputs.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            pend_abort_q <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awaddr_q     <= '0;
            araddr_q     <= '0;
            wdata_q      <= '0;
            wack_q       <= 1'b0;
            rack_q       <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pend_abort_q <= pend_abort_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awaddr_q     <= awaddr_d;
            araddr_q     <= araddr_d;
            wdata_q      <= wdata_d;
            wack_q       <= wack_d;
            rack_q       <= rack_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        pend_abort_d = pend_abort_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awaddr_d     = awaddr_q;
        araddr_d     = araddr_q;
        wdata_d      = wdata_q;
        wack_d       = 1'b0;
        rack_d       = 1'b0;
        err_d        = 1'b0;
        rdata_d      = '0;
        aw_left      = 1'b0;
        w_left       = 1'b0;
        write_done   = 1'b0;
        write_abort  = 1'b0;
        read_abort   = 1'b0;

        // >= so a late address handshake cannot carry the count past the limit.
        timeout = (state_q != S_IDLE) && (cnt_q >= TO_LAST);

        if (state_q != S_IDLE) begin
            cnt_d = cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (pend_abort_q) begin
                    // Pending read dropped by a timed-out write: fail it now.
                    rack_d       = 1'b1;
                    err_d        = 1'b1;
                    rdata_d      = DEAD_DATA;
                    pend_d       = 1'b0;
                    pend_abort_d = 1'b0;
                end else if (!busy_q) begin
                    if (up_wreq) begin
                        state_d   = S_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = up_to_axi(up_waddr);
                        wdata_d   = up_wdata;
                        cnt_d     = '0;
                        if (up_rreq) begin
                            pend_d   = 1'b1;
                            araddr_d = up_to_axi(up_raddr);
                        end
                    end else if (up_rreq) begin
                        state_d   = S_RD_ADDR;
                        arvalid_d = 1'b1;
                        araddr_d  = up_to_axi(up_raddr);
                        cnt_d     = '0;
                    end
                end
            end
            S_WR: begin
                // AW and W retire independently; leave once both are done.
                aw_left = awvalid_q && !m_axi_awready;
                w_left  = wvalid_q && !m_axi_wready;
                if (timeout) begin
                    awvalid_d   = 1'b0;
                    wvalid_d    = 1'b0;
                    write_abort = 1'b1;
                end else begin
                    awvalid_d = aw_left;
                    wvalid_d  = w_left;
                    if (!aw_left && !w_left) begin
                        state_d  = S_WR_RESP;
                        bready_d = 1'b1;
                    end
                end
            end
            S_WR_RESP: begin
                if (m_axi_bvalid) begin
                    bready_d   = 1'b0;
                    wack_d     = 1'b1;
                    err_d      = (m_axi_bresp != 2'b00);
                    write_done = 1'b1;
                end else if (timeout) begin
                    bready_d    = 1'b0;
                    write_abort = 1'b1;
                end
            end
            S_RD_ADDR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_DATA;
                end else if (timeout) begin
                    arvalid_d  = 1'b0;
                    read_abort = 1'b1;
                end
            end
            S_RD_DATA: begin
                if (m_axi_rvalid) begin
                    rready_d = 1'b0;
                    rack_d   = 1'b1;
                    err_d    = (m_axi_rresp != 2'b00);
                    rdata_d  = m_axi_rdata;
                    state_d  = S_IDLE;
                end else if (timeout) begin
                    rready_d   = 1'b0;
                    read_abort = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Write finished normally: chain straight into a pending read.
        if (write_done) begin
            if (pend_q) begin
                state_d   = S_RD_ADDR;
                arvalid_d = 1'b1;
                pend_d    = 1'b0;
                cnt_d     = '0;
            end else begin
                state_d = S_IDLE;
            end
        end

        // Write aborted: the pending read (if any) is failed on the next cycle.
        if (write_abort) begin
            state_d      = S_IDLE;
            wack_d       = 1'b1;
            err_d        = 1'b1;
            pend_abort_d = pend_q;
        end

        if (read_abort) begin
            state_d = S_IDLE;
            rack_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = DEAD_DATA;
        end

        // Busy covers the ack cycle so a new request cannot race the ack.
        busy_d = (state_d != S_IDLE) || pend_d || wack_d || rack_d;
    end

    assign up_wack       = wack_q;
    assign up_rack       = rack_q;
    assign up_err        = err_q;
    assign up_rdata      = rdata_q;
    assign up_busy       = busy_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = 4'hf;
    assign m_axi_bready  = bready_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_up_axi_master.sv
// Bench for up_axi_master: a configurable-latency AXI slave, a handshake
// monitor, and a timing/result reference derived from cycle arithmetic.
module tb_up_axi_master;

    localparam logic [31:0] BASE = 32'h44A00000;
    localparam int          TO   = 16;
    localparam logic [31:0] DEAD = 32'hdeaddead;
    localparam int          HANG = 1000;

    logic        up_clk = 1'b0;
    logic        up_rstn = 1'b0;
    logic        up_wreq = 1'b0;
    logic [13:0] up_waddr = '0;
    logic [31:0] up_wdata = '0;
    logic        up_wack;
    logic        up_rreq = 1'b0;
    logic [13:0] up_raddr = '0;
    logic [31:0] up_rdata;
    logic        up_rack;
    logic        up_err;
    logic        up_busy;
    logic        m_axi_awvalid;
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_wvalid;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_bready;
    logic        m_axi_arvalid;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_rready;

    // Slave-driven signals
    logic        s_awready = 1'b0;
    logic        s_wready  = 1'b0;
    logic        s_bvalid  = 1'b0;
    logic        s_arready = 1'b0;
    logic        s_rvalid  = 1'b0;

    // Slave configuration (wait cycles per channel, response values)
    int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic [1:0]  cfg_bresp = 2'b00;
    logic [1:0]  cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = '0;

    int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;

    // Monitor state
    int          cyc = 0;
    int          hs_aw = 0, hs_w = 0, hs_ar = 0;
    logic [31:0] seen_awaddr = '0, seen_wdata = '0, seen_araddr = '0;
    logic [3:0]  seen_wstrb = '0;
    logic [5:0]  seen_prot = '0;
    int          n_wack = 0;
    int          ar_rise = 0;
    int          viol = 0;
    logic        pv_aw = 1'b0, pr_aw = 1'b0, pv_w = 1'b0, pr_w = 1'b0, pv_ar = 1'b0, pr_ar = 1'b0;
    logic [31:0] pa_aw = '0, pd_w = '0, pa_ar = '0;

    int checks = 0;
    int failures = 0;
    int t0 = 0;

    up_axi_master #(
        .AXI_ADDRESS_BASE (BASE),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .up_clk        (up_clk),
        .up_rstn       (up_rstn),
        .up_wreq       (up_wreq),
        .up_waddr      (up_waddr),
        .up_wdata      (up_wdata),
        .up_wack       (up_wack),
        .up_rreq       (up_rreq),
        .up_raddr      (up_raddr),
        .up_rdata      (up_rdata),
        .up_rack       (up_rack),
        .up_err        (up_err),
        .up_busy       (up_busy),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (s_awready),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (s_wready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_bvalid  (s_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_bresp   (cfg_bresp),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (s_arready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_rvalid  (s_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axi_rdata   (cfg_rdata),
        .m_axi_rresp   (cfg_rresp)
    );

    always #5 up_clk = ~up_clk;

    // Slave: each channel responds after its configured number of wait cycles.
    always @(negedge up_clk) begin
        if (m_axi_awvalid) begin s_awready <= (aw_c >= aw_wait); aw_c <= aw_c + 1; end
        else begin s_awready <= 1'b0; aw_c <= 0; end
        if (m_axi_wvalid) begin s_wready <= (w_c >= w_wait); w_c <= w_c + 1; end
        else begin s_wready <= 1'b0; w_c <= 0; end
        if (m_axi_bready) begin s_bvalid <= (b_c >= b_wait); b_c <= b_c + 1; end
        else begin s_bvalid <= 1'b0; b_c <= 0; end
        if (m_axi_arvalid) begin s_arready <= (ar_c >= ar_wait); ar_c <= ar_c + 1; end
        else begin s_arready <= 1'b0; ar_c <= 0; end
        if (m_axi_rready) begin s_rvalid <= (r_c >= r_wait); r_c <= r_c + 1; end
        else begin s_rvalid <= 1'b0; r_c <= 0; end
    end

    // Monitor: handshakes, ack counts, and payload stability while stalled.
    always @(posedge up_clk) begin
        cyc <= cyc + 1;
        if (m_axi_awvalid && s_awready) begin
            hs_aw <= hs_aw + 1; seen_awaddr <= m_axi_awaddr; seen_prot <= {m_axi_awprot, m_axi_arprot};
        end
        if (m_axi_wvalid && s_wready) begin
            hs_w <= hs_w + 1; seen_wdata <= m_axi_wdata; seen_wstrb <= m_axi_wstrb;
        end
        if (m_axi_arvalid && s_arready) begin
            hs_ar <= hs_ar + 1; seen_araddr <= m_axi_araddr;
        end
        if (m_axi_arvalid && !pv_ar) ar_rise <= cyc;
        if (up_wack) n_wack <= n_wack + 1;
        if (pv_aw && !pr_aw && m_axi_awvalid && m_axi_awaddr != pa_aw) viol <= viol + 1;
        if (pv_w && !pr_w && m_axi_wvalid && m_axi_wdata != pd_w) viol <= viol + 1;
        if (pv_ar && !pr_ar && m_axi_arvalid && m_axi_araddr != pa_ar) viol <= viol + 1;
        pv_aw <= m_axi_awvalid; pr_aw <= s_awready; pa_aw <= m_axi_awaddr;
        pv_w  <= m_axi_wvalid;  pr_w  <= s_wready;  pd_w  <= m_axi_wdata;
        pv_ar <= m_axi_arvalid; pr_ar <= s_arready; pa_ar <= m_axi_araddr;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input logic [13:0] a);
        return BASE + (32'(a) * 4);
    endfunction

    // Issue one request (write, read, or both) and check it against the reference.
    task automatic xact(input string tag, input bit do_w, input bit do_r,
                        input logic [13:0] wa, input logic [31:0] wd, input logic [13:0] ra,
                        input int aw, input int w, input int b, input int ar, input int r,
                        input logic [1:0] br, input logic [1:0] rr, input logic [31:0] rd);
        int wlat, rlat, got_w, got_r, haw, hw, har;
        bit w_to, r_to;
        logic werr, rerr;
        logic [31:0] rdat;
        logic [4:0] vr;
        aw_wait = aw; w_wait = w; b_wait = b; ar_wait = ar; r_wait = r;
        cfg_bresp = br; cfg_rresp = rr; cfg_rdata = rd;
        haw = hs_aw; hw = hs_w; har = hs_ar;

        // Reference: 3 cycles baseline, each slave wait adds one, timeout acks at TO+1.
        wlat = 0; rlat = 0; w_to = 1'b0; r_to = 1'b0;
        if (do_w) begin
            wlat = 3 + ((aw > w) ? aw : w) + b;
            w_to = (wlat - 1 > TO);
            if (w_to) wlat = TO + 1;
        end
        if (do_r) begin
            if (do_w && w_to) begin
                rlat = wlat + 1;
                r_to = 1'b1;
            end else begin
                rlat = 3 + ar + r;
                r_to = (rlat - 1 > TO);
                if (r_to) rlat = TO + 1;
                if (do_w) rlat = rlat + wlat - 1;
            end
        end

        @(negedge up_clk);
        up_wreq = do_w; up_waddr = wa; up_wdata = wd;
        up_rreq = do_r; up_raddr = ra;
        t0 = cyc;
        @(negedge up_clk);
        up_wreq = 1'b0; up_rreq = 1'b0;
        chk({tag, "_busy_rise"}, 32'(up_busy), 32'd1);

        got_w = -1; got_r = -1; werr = 1'b0; rerr = 1'b0; rdat = '0; vr = '1;
        for (int k = 0; k < 100; k++) begin
            if (up_wack && got_w < 0) begin got_w = cyc - t0; werr = up_err; end
            if (up_rack && got_r < 0) begin got_r = cyc - t0; rerr = up_err; rdat = up_rdata; end
            if ((!do_w || got_w >= 0) && (!do_r || got_r >= 0)) begin
                vr = {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready};
                break;
            end
            @(negedge up_clk);
        end

        if (do_w) begin
            chk({tag, "_wack_cycle"}, 32'(got_w), 32'(wlat));
            chk({tag, "_werr"}, 32'(werr), 32'(w_to || br != 2'b00));
            if (!w_to) begin
                chk({tag, "_aw_count"}, 32'(hs_aw - haw), 32'd1);
                chk({tag, "_w_count"}, 32'(hs_w - hw), 32'd1);
                chk({tag, "_awaddr"}, seen_awaddr, exp_addr(wa));
                chk({tag, "_wdata"}, seen_wdata, wd);
                chk({tag, "_wstrb"}, 32'(seen_wstrb), 32'hf);
                chk({tag, "_prot"}, 32'(seen_prot), 32'd0);
            end
        end
        if (do_r) begin
            chk({tag, "_rack_cycle"}, 32'(got_r), 32'(rlat));
            chk({tag, "_rerr"}, 32'(rerr), 32'(r_to || rr != 2'b00));
            chk({tag, "_rdata"}, rdat, r_to ? DEAD : rd);
            if (!r_to) begin
                chk({tag, "_ar_count"}, 32'(hs_ar - har), 32'd1);
                chk({tag, "_araddr"}, seen_araddr, exp_addr(ra));
            end
        end
        chk({tag, "_valids_at_ack"}, 32'(vr), 32'd0);
        @(negedge up_clk);
        chk({tag, "_after_ack"}, {up_rdata[30:0], up_busy}, 32'd0);
        chk({tag, "_acks_low"}, 32'({up_wack, up_rack, up_err}), 32'd0);
    endtask

    initial begin
        int snap;
        int kind;

        // Reset state
        repeat (3) @(negedge up_clk);
        chk("reset_outputs", 32'({up_wack, up_rack, up_err, up_busy, m_axi_awvalid, m_axi_wvalid,
                                  m_axi_bready, m_axi_arvalid, m_axi_rready}), 32'd0);
        chk("reset_rdata", up_rdata, 32'd0);
        up_rstn = 1'b1;
        repeat (2) @(negedge up_clk);

        // Zero-wait write, cycle by cycle
        @(negedge up_clk);
        up_wreq = 1'b1; up_waddr = 14'h0010; up_wdata = 32'h12345678;
        @(negedge up_clk);
        up_wreq = 1'b0;
        chk("zw_c1_valids", 32'({m_axi_awvalid, m_axi_wvalid, up_busy}), 32'h7);
        chk("zw_c1_awaddr", m_axi_awaddr, 32'h44A00040);
        chk("zw_c1_wstrb", 32'(m_axi_wstrb), 32'hf);
        @(negedge up_clk);
        chk("zw_c2_bready", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 32'h1);
        @(negedge up_clk);
        chk("zw_c3_wack", 32'({up_wack, up_err, up_busy}), 32'h5);
        chk("zw_c3_rdata", up_rdata, 32'd0);
        chk("zw_wdata", seen_wdata, 32'h12345678);
        @(negedge up_clk);
        chk("zw_c4_idle", 32'({up_wack, up_busy}), 32'd0);

        // Read with 5 address wait cycles
        xact("rd_wait", 1'b0, 1'b1, '0, '0, 14'h0123, 0, 0, 0, 5, 0, 2'b00, 2'b00, 32'hCAFEF00D);

        // Simultaneous write + read: write first, read chained after its ack
        xact("wr_rd", 1'b1, 1'b1, 14'h0001, 32'hA5A5_0001, 14'h0002, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0BAD_F00D);
        chk("wr_rd_ar_after_wack", 32'(ar_rise - t0), 32'd3);

        // W two cycles ahead of AW, SLVERR response, exactly one ack
        snap = n_wack;
        xact("w_first_slverr", 1'b1, 1'b0, 14'h0200, 32'h1111_2222, '0, 2, 0, 0, 0, 0, 2'b10, 2'b00, '0);
        chk("w_first_single_ack", 32'(n_wack - snap), 32'd1);

        // Read that never gets AR accepted: timeout, then a normal write
        xact("rd_timeout", 1'b0, 1'b1, '0, '0, 14'h0042, 0, 0, 0, HANG, 0, 2'b00, 2'b00, 32'h1234_5678);
        xact("wr_after_to", 1'b1, 1'b0, 14'h0007, 32'hDEAD_BEEF, '0, 0, 0, 0, 0, 0, 2'b00, 2'b00, '0);

        // Hung write with a pending read: both acks fail, read one cycle later
        xact("wr_to_pend", 1'b1, 1'b1, 14'h0030, 32'h7777_8888, 14'h0031, HANG, 0, 0, 0, 0, 2'b00, 2'b00, 32'h5555_5555);

        // Reset while waiting for B: silent abort
        aw_wait = 0; w_wait = 0; b_wait = HANG;
        @(negedge up_clk);
        up_wreq = 1'b1; up_waddr = 14'h0050; up_wdata = 32'h0F0F_0F0F;
        @(negedge up_clk);
        up_wreq = 1'b0;
        repeat (2) @(negedge up_clk);
        chk("rst_pre_bready", 32'(m_axi_bready), 32'd1);
        snap = n_wack;
        #2 up_rstn = 1'b0;
        #1 chk("rst_async_drop", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                                      m_axi_rready, up_busy, up_wack}), 32'd0);
        repeat (2) @(negedge up_clk);
        up_rstn = 1'b1;
        repeat (4) @(negedge up_clk);
        chk("rst_no_wack", 32'(n_wack - snap), 32'd0);
        chk("rst_idle", 32'(up_busy), 32'd0);
        xact("post_rst_rd", 1'b0, 1'b1, '0, '0, 14'h0009, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h600D_D00D);

        // Randomized traffic with small slave latencies and random responses
        for (int i = 0; i < 24; i++) begin
            kind = int'($urandom_range(0, 2));
            xact($sformatf("rnd%0d", i), kind != 1, kind != 0,
                 14'($urandom), $urandom, 14'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 2'($urandom), 2'($urandom), $urandom);
        end

        chk("payload_stable", 32'(viol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
